// File: rtl/display_scheduler.sv
// Display scheduler: shows the user-selected source page and briefly overlays
// any other source that reports a change. Overlays queue up in a pending mask
// and are shown one after another, lowest index first.
// Optional feature: define DISP_AUTOSCAN_EN to advance the page automatically
// after AUTOSCAN_CYCLES idle cycles in SHOW.
module display_scheduler #(
  parameter int unsigned HOLD_CYCLES     = 150000000,
  parameter int unsigned AUTOSCAN_CYCLES = 500000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sel_btn,
  input  logic [99:0]  src_value,
  input  logic [4:0]   upd_pulse,
  output logic [19:0]  value,
  output logic [3:0]   mode,
  output logic [2:0]   page,
  output logic         overlay_active
);

  // Both durations are loaded as N-1, so zero would underflow.
  if (HOLD_CYCLES == 0 || AUTOSCAN_CYCLES == 0) begin : g_bad_param
    $error("display_scheduler: HOLD_CYCLES and AUTOSCAN_CYCLES must be nonzero");
  end

  localparam logic [31:0] HoldLast = 32'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {StShow, StOverlay} state_e;

  state_e      state_q, state_d;
  logic [2:0]  page_q, page_d;
  logic [2:0]  ovl_src_q, ovl_src_d;
  logic [4:0]  pending_q, pending_d;
  logic [31:0] timer_q, timer_d;
  logic [19:0] value_q, value_d;
  logic [3:0]  mode_q, mode_d;
  logic        ovl_act_q, ovl_act_d;

  // Scratch terms for next-state evaluation.
  logic [2:0]  page_eff;
  logic [4:0]  upd_eff;
  logic [4:0]  pend_merge;
  logic [4:0]  pend_avail;
  logic [2:0]  disp_idx;

`ifdef DISP_AUTOSCAN_EN
  localparam logic [31:0] ScanLast = 32'(AUTOSCAN_CYCLES - 1);
  logic [31:0] scan_q, scan_d;
`endif

  function automatic logic [2:0] next_page(input logic [2:0] p);
    return (p == 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

  function automatic logic [4:0] idx_onehot(input logic [2:0] i);
    return 5'b00001 << i;
  endfunction

  function automatic logic [2:0] lowest_idx(input logic [4:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 4; k >= 0; k--) begin
      if (v[k]) r = 3'(k);
    end
    return r;
  endfunction

  // Next-state logic for the SHOW/OVERLAY FSM, page, pending mask and timer.
  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    ovl_src_d  = ovl_src_q;
    pending_d  = pending_q;
    timer_d    = timer_q;
    page_eff   = page_q;
    upd_eff    = 5'b0;
    pend_merge = 5'b0;
    pend_avail = 5'b0;
`ifdef DISP_AUTOSCAN_EN
    scan_d     = scan_q;
`endif
    case (state_q)
      StShow: begin
        // Page change is applied first so updates compare against the new page.
        if (sel_btn) page_eff = next_page(page_q);
`ifdef DISP_AUTOSCAN_EN
        if (sel_btn) begin
          scan_d = 32'd0;
        end else if (scan_q == ScanLast) begin
          page_eff = next_page(page_q);
          scan_d   = 32'd0;
        end else begin
          scan_d = scan_q + 32'd1;
        end
`endif
        page_d  = page_eff;
        upd_eff = upd_pulse & ~idx_onehot(page_eff);
        if (upd_eff != 5'b0) begin
          state_d   = StOverlay;
          ovl_src_d = lowest_idx(upd_eff);
          pending_d = upd_eff & ~idx_onehot(lowest_idx(upd_eff));
          timer_d   = HoldLast;
`ifdef DISP_AUTOSCAN_EN
          scan_d    = 32'd0;
`endif
        end
      end
      StOverlay: begin
`ifdef DISP_AUTOSCAN_EN
        scan_d     = 32'd0;
`endif
        upd_eff    = upd_pulse & ~idx_onehot(page_q);
        pend_merge = pending_q | (upd_eff & ~idx_onehot(ovl_src_q));
        pend_avail = pend_merge & ~idx_onehot(page_q);
        if (sel_btn) begin
          // Adopt the overlaid source as the page and drop the queue.
          page_d    = ovl_src_q;
          pending_d = 5'b0;
          timer_d   = 32'd0;
          state_d   = StShow;
        end else if (upd_eff[ovl_src_q]) begin
          timer_d   = HoldLast;
          pending_d = pend_merge;
        end else if (timer_q == 32'd0) begin
          if (pend_avail != 5'b0) begin
            ovl_src_d = lowest_idx(pend_avail);
            pending_d = pend_avail & ~idx_onehot(lowest_idx(pend_avail));
            timer_d   = HoldLast;
          end else begin
            pending_d = 5'b0;
            state_d   = StShow;
          end
        end else begin
          timer_d   = timer_q - 32'd1;
          pending_d = pend_merge;
        end
      end
      default: state_d = StShow;
    endcase
  end

  // Output next-state: select the displayed source from the current state.
  always_comb begin
    disp_idx = (state_q == StOverlay) ? ovl_src_q : page_q;
    value_d  = src_value[19:0];
    case (disp_idx)
      3'd1:    value_d = src_value[39:20];
      3'd2:    value_d = src_value[59:40];
      3'd3:    value_d = src_value[79:60];
      3'd4:    value_d = src_value[99:80];
      default: value_d = src_value[19:0];
    endcase
    mode_d    = {1'b0, disp_idx};
    ovl_act_d = (state_q == StOverlay);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StShow;
      page_q    <= 3'd0;
      ovl_src_q <= 3'd0;
      pending_q <= 5'b0;
      timer_q   <= 32'd0;
      value_q   <= 20'd0;
      mode_q    <= 4'd0;
      ovl_act_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      ovl_src_q <= ovl_src_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      value_q   <= value_d;
      mode_q    <= mode_d;
      ovl_act_q <= ovl_act_d;
    end
  end

`ifdef DISP_AUTOSCAN_EN
  // Idle counter for automatic page advance.
  always_ff @(posedge clk) begin
    if (rst) scan_q <= 32'd0;
    else     scan_q <= scan_d;
  end
`endif

  assign value          = value_q;
  assign mode           = mode_q;
  assign page           = page_q;
  assign overlay_active = ovl_act_q;

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 150000000, giving the overlay display duration in clk cycles (1.5 s at 100 MHz).
REQ-002 The block SHALL have parameter AUTOSCAN_CYCLES, default 500000000, giving the idle time before an automatic page advance (used only under REQ-024).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port sel_btn, input, 1 bit: a debounced, single-cycle page-select pulse.
REQ-006 The block SHALL have port src_value, input, 100 bits: five 20-bit source values, where source k occupies bits [20k+19:20k] (0 freq, 1 phase, 2 duty, 3 sweep range, 4 sweep speed).
REQ-007 The block SHALL have port upd_pulse, input, 5 bits: bit k is a single-cycle strobe meaning source k changed.
REQ-008 The block SHALL have port value, output, 20 bits: the value to display, registered.
REQ-009 The block SHALL have port mode, output, 4 bits: the display mode, equal to the index of the displayed source, registered.
REQ-010 The block SHALL have port page, output, 3 bits: the user-selected page, 0..4.
REQ-011 The block SHALL have port overlay_active, output, 1 bit: high while a transient overlay is shown.

Function
REQ-012 The page register SHALL increment on sel_btn while in SHOW, wrapping from 4 to 0.
REQ-013 The FSM SHALL have exactly two states: SHOW and OVERLAY.
- SHOW displays the source at index page.
- OVERLAY displays the source at index ovl_src.
REQ-014 In SHOW, when upd_pulse has any bit set other than the bit at index page, the FSM SHALL enter OVERLAY.
- ovl_src = lowest set index excluding page.
- The hold timer loads HOLD_CYCLES-1.
- Any other set bits, excluding page, go into the 5-bit pending register.
REQ-015 An upd_pulse bit equal to the current page SHALL be ignored in every state.
REQ-016 In OVERLAY, the timer SHALL decrement by 1 per cycle, and an upd_pulse for ovl_src SHALL reload it to HOLD_CYCLES-1 (restart).
REQ-017 In OVERLAY, an upd_pulse for any other non-page source SHALL set that source's pending bit, and a bit already set SHALL remain set.
REQ-018 When the timer is 0 and no restart occurs in that cycle, the FSM SHALL act on the pending register, with pending bits at index page excluded:
- If pending is non-zero, ovl_src = lowest pending index, that bit clears, the timer reloads, and the FSM stays in OVERLAY.
- Otherwise the FSM returns to SHOW.
REQ-019 On sel_btn in OVERLAY, the block SHALL:
- set page = ovl_src;
- clear pending;
- go to SHOW;
- take no page increment.
REQ-020 When sel_btn and upd_pulse occur in the same SHOW cycle, sel_btn SHALL take effect first, and upd_pulse SHALL be evaluated against the new page value.
REQ-021 The value, mode and overlay_active outputs SHALL be registered with one-cycle latency from a state, page or ovl_src change, and value SHALL track the displayed source's src_value live with one-cycle latency.
REQ-022 The mode output SHALL be zero-extended from the 3-bit source index, so only values 0..4 are ever output.

Reset
REQ-023 On rst high at a clk edge, the block SHALL set:
- state = SHOW, page = 0, ovl_src = 0, pending = 0, timer = 0, autoscan counter = 0;
- outputs value = 0, mode = 0, page = 0, overlay_active = 0.
- Reset mid-overlay discards the overlay and all pending bits.
- The first non-reset cycle behaves as SHOW with page 0.

Configuration
REQ-024 With DISP_AUTOSCAN_EN defined, the block SHALL count cycles in SHOW, and when the count reaches AUTOSCAN_CYCLES-1 it SHALL advance page (wrapping 4 to 0) and clear the counter.
- sel_btn clears the counter.
- Any OVERLAY entry clears the counter.
- The counter holds at 0 while in OVERLAY.
REQ-025 Without DISP_AUTOSCAN_EN, the block SHALL contain no autoscan counter, and page SHALL change only per REQ-012 and REQ-019.

Verification (bench uses HOLD_CYCLES=10, AUTOSCAN_CYCLES=20)
REQ-026 Reset, then 3 sel_btn pulses SHALL give page=3, mode=3, value=src[3]; 2 more pulses SHALL give page=0.
REQ-027 With page=0, upd_pulse=5'b00100 SHALL raise overlay_active next cycle with mode=2, hold for 10 cycles, then return to mode=0 with overlay_active=0.
REQ-028 With page=0, upd_pulse=5'b10110 SHALL show source 1 for 10 cycles, then 2 for 10 cycles, then 4 for 10 cycles, then SHOW page 0.
REQ-029 During an overlay of source 2:
- upd_pulse[2] at timer=3 SHALL extend the overlay to 10 further cycles;
- sel_btn SHALL then give page=2, overlay_active=0, pending=0.
REQ-030 Simultaneous sel_btn and upd_pulse=5'b00010 at page=0 SHALL give page=1 and no overlay; a rst pulse mid-overlay SHALL give all outputs 0 next cycle.
REQ-031 With DISP_AUTOSCAN_EN and no input activity, page SHALL advance every 20 cycles (0, 1, 2, 3, 4, 0); without DISP_AUTOSCAN_EN, page SHALL stay 0.
